// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock flag FIFO: count width helper and
// the read-mode selector values.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy counters need one bit more than the RAM address to reach DEPTH.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Array contents are never reset; only the read register clears.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; clears on reset so the reader sees zero.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_flags_fwft.sv
// Single-clock FIFO with full/prog_full/empty/prog_empty flags, live
// occupancy count and an elaboration-time read mode (standard or FWFT).
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs.
//
// FWFT read path is two stages: the RAM read register (stage, valid sv) and
// the output register (valid ov). The staged word is still counted in
// ram_count, so data_count = ram_count + ov and capacity is DEPTH+1.
// A write into an empty FIFO at edge N is fetched at N+1 and presented at
// N+2; while the RAM keeps data, pops are refilled back-to-back.
module sync_fifo_flags_fwft
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 1,
  parameter int RESERVE    = 0,
  parameter int PE_THRESH  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 full,
  output logic                                 prog_full,
  input  logic                                 rd_en,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 empty,
  output logic                                 has_data,
  output logic                                 prog_empty,
  output logic [count_width(ADDR_WIDTH)-1:0]   data_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                                 overflow,
  output logic                                 underflow
`endif
);

  localparam int CW    = count_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] PF_LEVEL = CW'(DEPTH - RESERVE);
  localparam logic [CW-1:0] PE_LEVEL = CW'(PE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         ram_count;
  logic                  wr_acc;
  logic                  ram_re;
  logic                  ram_dec;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign wr_acc     = wr_en & ~full;
  assign full       = (ram_count == DEPTH_C);
  assign prog_full  = (ram_count >= PF_LEVEL);
  assign has_data   = ~empty;
  assign prog_empty = (data_count <= PE_LEVEL);

  // Pointers and RAM occupancy; ram_dec is the mode-specific "word left RAM".
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (ram_re) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_count <= ram_count + CW'(wr_acc) - CW'(ram_dec);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc & ~rst),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .re   (ram_re & ~rst),
    .raddr(rd_ptr),
    .rdata(ram_dout)
  );

  if (FWFT != FIFO_MODE_STD) begin : g_fwft
    logic                  ov;
    logic                  sv;
    logic                  pop;
    logic                  move;
    logic                  fetch;
    logic [DATA_WIDTH-1:0] out_q;

    assign pop   = rd_en & ov;
    // Staged word advances when the output slot is free or being popped.
    assign move  = sv & (~ov | rd_en);
    // RAM words not yet fetched = ram_count - sv; refill stage when it frees.
    assign fetch = (ram_count != CW'(sv)) & (~sv | move);

    assign ram_re     = fetch;
    assign ram_dec    = move;
    assign rd_data    = out_q;
    assign empty      = ~ov;
    assign data_count = ram_count + CW'(ov);

    // Stage and output-register valid bits plus the presented word.
    always_ff @(posedge clk) begin
      if (rst) begin
        ov    <= 1'b0;
        sv    <= 1'b0;
        out_q <= '0;
      end else begin
        if (move) begin
          out_q <= ram_dout;
          ov    <= 1'b1;
        end else if (pop) begin
          ov    <= 1'b0;
        end
        if (fetch)     sv <= 1'b1;
        else if (move) sv <= 1'b0;
      end
    end
  end else begin : g_std
    logic rd_acc;

    assign rd_acc     = rd_en & ~empty;
    assign ram_re     = rd_acc;
    assign ram_dec    = rd_acc;
    assign rd_data    = ram_dout;
    assign empty      = (ram_count == '0);
    assign data_count = ram_count;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags_fwft.sv
// Directed bench for sync_fifo_flags_fwft: one FWFT instance (RESERVE=4,
// PE_THRESH=1) and one standard instance (RESERVE=0, PE_THRESH=2).
// Error-flag steps are compiled when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_flags_fwft;
  import sync_fifo_pkg::*;

  logic       clk;
  logic       rst;

  logic       fw_wr_en, fw_rd_en;
  logic [7:0] fw_wr_data, fw_rd_data;
  logic       fw_full, fw_prog_full, fw_empty, fw_has_data, fw_prog_empty;
  logic [4:0] fw_dc;

  logic       sd_wr_en, sd_rd_en;
  logic [7:0] sd_wr_data, sd_rd_data;
  logic       sd_full, sd_prog_full, sd_empty, sd_has_data, sd_prog_empty;
  logic [4:0] sd_dc;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic fw_overflow, fw_underflow, sd_overflow, sd_underflow;
`endif

  int vectors = 0;
  int errs    = 0;

  sync_fifo_flags_fwft #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(FIFO_MODE_FWFT), .RESERVE(4), .PE_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst(rst),
    .wr_en(fw_wr_en), .wr_data(fw_wr_data), .full(fw_full), .prog_full(fw_prog_full),
    .rd_en(fw_rd_en), .rd_data(fw_rd_data), .empty(fw_empty), .has_data(fw_has_data),
    .prog_empty(fw_prog_empty), .data_count(fw_dc)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(fw_overflow), .underflow(fw_underflow)
`endif
  );

  sync_fifo_flags_fwft #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(FIFO_MODE_STD), .RESERVE(0), .PE_THRESH(2)
  ) u_std (
    .clk(clk), .rst(rst),
    .wr_en(sd_wr_en), .wr_data(sd_wr_data), .full(sd_full), .prog_full(sd_prog_full),
    .rd_en(sd_rd_en), .rd_data(sd_rd_data), .empty(sd_empty), .has_data(sd_has_data),
    .prog_empty(sd_prog_empty), .data_count(sd_dc)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(sd_overflow), .underflow(sd_underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_fw(input string tag);
    chk({tag, "_fw_empty"}, 32'(fw_empty), 1);
    chk({tag, "_fw_has"},   32'(fw_has_data), 0);
    chk({tag, "_fw_full"},  32'(fw_full), 0);
    chk({tag, "_fw_pf"},    32'(fw_prog_full), 0);
    chk({tag, "_fw_pe"},    32'(fw_prog_empty), 1);
    chk({tag, "_fw_dc"},    32'(fw_dc), 0);
    chk({tag, "_fw_rd"},    32'(fw_rd_data), 0);
  endtask

  task automatic chk_reset_sd(input string tag);
    chk({tag, "_sd_empty"}, 32'(sd_empty), 1);
    chk({tag, "_sd_has"},   32'(sd_has_data), 0);
    chk({tag, "_sd_full"},  32'(sd_full), 0);
    chk({tag, "_sd_pf"},    32'(sd_prog_full), 0);
    chk({tag, "_sd_pe"},    32'(sd_prog_empty), 1);
    chk({tag, "_sd_dc"},    32'(sd_dc), 0);
    chk({tag, "_sd_rd"},    32'(sd_rd_data), 0);
  endtask

  initial begin
    rst = 1'b1;
    fw_wr_en = 1'b0; fw_rd_en = 1'b0; fw_wr_data = 8'h00;
    sd_wr_en = 1'b0; sd_rd_en = 1'b0; sd_wr_data = 8'h00;
    tick();
    tick();
    chk_reset_fw("rst0");
    chk_reset_sd("rst0");
    rst = 1'b0;

    // 1: FWFT fill to DEPTH+1 words, prog_full at ram_count 12 (data_count 13).
    for (int k = 1; k <= 17; k++) begin
      fw_wr_en = 1'b1; fw_wr_data = 8'(32'h10 + k);
      tick();
      chk("t1_dc",    32'(fw_dc), 32'(k));
      chk("t1_pf",    32'(fw_prog_full), 32'(k >= 13));
      chk("t1_full",  32'(fw_full), 32'(k == 17));
      chk("t1_empty", 32'(fw_empty), 32'(k < 3));
    end
    fw_wr_data = 8'hEE;
    tick();
    fw_wr_en = 1'b0;
    chk("t1_drop_dc",   32'(fw_dc), 17);
    chk("t1_drop_full", 32'(fw_full), 1);
    for (int k = 1; k <= 17; k++) begin
      chk("t1_drain_rd", 32'(fw_rd_data), 32'(8'(32'h10 + k)));
      chk("t1_drain_dc", 32'(fw_dc), 32'(18 - k));
      fw_rd_en = 1'b1;
      tick();
    end
    fw_rd_en = 1'b0;
    chk("t1_end_empty", 32'(fw_empty), 1);
    chk("t1_end_dc",    32'(fw_dc), 0);

    // 2: FWFT first-word latency.
    fw_wr_en = 1'b1; fw_wr_data = 8'hA5;
    tick();
    fw_wr_en = 1'b0;
    chk("t2_n_empty", 32'(fw_empty), 1);
    tick();
    chk("t2_n1_empty", 32'(fw_empty), 1);
    tick();
    chk("t2_n2_empty", 32'(fw_empty), 0);
    chk("t2_n2_rd",    32'(fw_rd_data), 32'hA5);
    chk("t2_n2_dc",    32'(fw_dc), 1);
    chk("t2_n2_pe",    32'(fw_prog_empty), 1);
    fw_rd_en = 1'b1;
    tick();
    fw_rd_en = 1'b0;
    chk("t2_pop_empty", 32'(fw_empty), 1);
    chk("t2_pop_dc",    32'(fw_dc), 0);

    // 3: standard mode reads and prog_empty with PE_THRESH=2.
    for (int k = 1; k <= 3; k++) begin
      sd_wr_en = 1'b1; sd_wr_data = 8'(32'h30 + k);
      tick();
      chk("t3_wr_dc",    32'(sd_dc), 32'(k));
      chk("t3_wr_pe",    32'(sd_prog_empty), 32'(k <= 2));
      chk("t3_wr_empty", 32'(sd_empty), 0);
    end
    sd_wr_en = 1'b0;
    sd_rd_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t3_rd_data", 32'(sd_rd_data), 32'(8'(32'h30 + k)));
      chk("t3_rd_dc",   32'(sd_dc), 32'(3 - k));
      chk("t3_rd_pe",   32'(sd_prog_empty), 1);
    end
    tick();
    sd_rd_en = 1'b0;
    chk("t3_ign_data",  32'(sd_rd_data), 32'h33);
    chk("t3_ign_dc",    32'(sd_dc), 0);
    chk("t3_ign_empty", 32'(sd_empty), 1);

    // 4: streaming in both modes after priming one word; pointers wrap.
    fw_wr_en = 1'b1; fw_wr_data = 8'h40;
    sd_wr_en = 1'b1; sd_wr_data = 8'h40;
    tick();
    for (int i = 1; i <= 40; i++) begin
      fw_wr_en = 1'b1; fw_rd_en = 1'b1; fw_wr_data = 8'(32'h40 + i);
      sd_wr_en = 1'b1; sd_rd_en = 1'b1; sd_wr_data = 8'(32'h40 + i);
      tick();
      chk("t4_sd_rd", 32'(sd_rd_data), 32'(8'(32'h40 + i - 1)));
      chk("t4_sd_dc", 32'(sd_dc), 1);
      chk("t4_fw_dc", 32'(fw_dc), (i == 1) ? 32'd2 : 32'd3);
      if (i >= 2) begin
        chk("t4_fw_rd",    32'(fw_rd_data), 32'(8'(32'h40 + i - 2)));
        chk("t4_fw_empty", 32'(fw_empty), 0);
      end
    end
    fw_wr_en = 1'b0; fw_rd_en = 1'b0;
    sd_wr_en = 1'b0; sd_rd_en = 1'b0;

    // 5: reset mid-traffic with 9 words held; enables during rst ignored.
    for (int k = 0; k < 6; k++) begin
      fw_wr_en = 1'b1; fw_wr_data = 8'(32'h50 + k);
      tick();
    end
    chk("t5_pre_dc", 32'(fw_dc), 9);
    rst = 1'b1;
    fw_wr_en = 1'b1; fw_rd_en = 1'b1; fw_wr_data = 8'h99;
    sd_wr_en = 1'b1; sd_rd_en = 1'b1; sd_wr_data = 8'h99;
    tick();
    rst = 1'b0;
    fw_wr_en = 1'b0; fw_rd_en = 1'b0;
    sd_wr_en = 1'b0; sd_rd_en = 1'b0;
    chk_reset_fw("t5");
    chk_reset_sd("t5");
    fw_wr_en = 1'b1; fw_wr_data = 8'h77;
    tick();
    fw_wr_data = 8'h78;
    tick();
    fw_wr_en = 1'b0;
    chk("t5_w2_empty", 32'(fw_empty), 1);
    tick();
    chk("t5_rd0",  32'(fw_rd_data), 32'h77);
    chk("t5_dc0",  32'(fw_dc), 2);
    fw_rd_en = 1'b1;
    tick();
    chk("t5_rd1",  32'(fw_rd_data), 32'h78);
    chk("t5_dc1",  32'(fw_dc), 1);
    tick();
    fw_rd_en = 1'b0;
    chk("t5_end_empty", 32'(fw_empty), 1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // 6: sticky error flags.
    chk("t6_fw_uf0", 32'(fw_underflow), 0);
    chk("t6_sd_of0", 32'(sd_overflow), 0);
    fw_rd_en = 1'b1;
    tick();
    fw_rd_en = 1'b0;
    chk("t6_fw_uf1", 32'(fw_underflow), 1);
    chk("t6_fw_of1", 32'(fw_overflow), 0);
    for (int k = 1; k <= 16; k++) begin
      sd_wr_en = 1'b1; sd_wr_data = 8'(k);
      tick();
    end
    chk("t6_sd_of_at_full", 32'(sd_overflow), 0);
    chk("t6_sd_full",       32'(sd_full), 1);
    tick();
    sd_wr_en = 1'b0;
    chk("t6_sd_of1", 32'(sd_overflow), 1);
    chk("t6_sd_uf1", 32'(sd_underflow), 0);
    sd_rd_en = 1'b1; fw_wr_en = 1'b1; fw_wr_data = 8'h12;
    tick();
    tick();
    sd_rd_en = 1'b0; fw_wr_en = 1'b0;
    chk("t6_sd_rd",     32'(sd_rd_data), 32'h02);
    chk("t6_sd_of_hold", 32'(sd_overflow), 1);
    chk("t6_fw_uf_hold", 32'(fw_underflow), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_fw_uf_clr", 32'(fw_underflow), 0);
    chk("t6_sd_of_clr", 32'(sd_overflow), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
